// File: rtl/cpu_program_counter_pkg.sv
// Shared constants and types for the PIC10-compatible fetch stage.
// Holds the instruction encodings the decoder uses to drive the control inputs.
package cpu_program_counter_pkg;

  localparam int               PC_WIDTH_DEFAULT     = 9;
  localparam logic [8:0]       RESET_VECTOR_DEFAULT = 9'h1FF;
  localparam int               STACK_LEVELS         = 2;
  localparam logic [11:0]      NOP_WORD             = 12'h000;

  // 12-bit baseline opcode patterns; k bits are don't-care in the masks.
  localparam logic [11:0]      OPC_GOTO_MASK  = 12'hE00;
  localparam logic [11:0]      OPC_GOTO       = 12'hA00;
  localparam logic [11:0]      OPC_CALL_MASK  = 12'hF00;
  localparam logic [11:0]      OPC_CALL       = 12'h900;
  localparam logic [11:0]      OPC_RETLW_MASK = 12'hF00;
  localparam logic [11:0]      OPC_RETLW      = 12'h800;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_PCL,
    SEL_GOTO,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

endpackage

// File: rtl/cpu_program_counter_if.sv
// Execute-stage control requests into the fetch stage, and the fetch-stage
// outputs back to the ROM, NOP-insert mux and debug logic.
interface cpu_program_counter_if
  import cpu_program_counter_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEFAULT
);

  logic                stall;
  logic                goto_en;
  logic                call_en;
  logic                retlw_en;
  logic                pcl_write_en;
  logic                skip_en;
  logic [8:0]          target;
  logic [7:0]          pcl_data;
  logic [PC_WIDTH-1:0] rom_addr;
  logic                nop_insert;
  logic [1:0]          stack_depth;

  modport master (
    output stall, goto_en, call_en, retlw_en, pcl_write_en, skip_en,
           target, pcl_data,
    input  rom_addr, nop_insert, stack_depth
  );

  modport slave (
    input  stall, goto_en, call_en, retlw_en, pcl_write_en, skip_en,
           target, pcl_data,
    output rom_addr, nop_insert, stack_depth
  );

endinterface

// File: rtl/cpu_call_stack.sv
// Two-level hardware return stack with saturating depth counter.
// Overflow silently drops the oldest entry; underflow keeps returning entry 0.
module cpu_call_stack
  import cpu_program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [1:0]       depth
);

  localparam logic [1:0] DEPTH_MAX = 2'(STACK_LEVELS);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]       depth_q,  depth_d;

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    depth_d  = depth_q;
    if (push) begin
      entry1_d = entry0_q;
      entry0_d = push_data;
      depth_d  = (depth_q == DEPTH_MAX) ? DEPTH_MAX : depth_q + 2'd1;
    end else if (pop) begin
      entry0_d = entry1_q;
      depth_d  = (depth_q == 2'd0) ? 2'd0 : depth_q - 2'd1;
    end
  end

  // NOTE: the entries are reset too, so a return on an empty stack yields a defined address.
  // NOTE: state flops use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
      depth_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      depth_q  <= depth_d;
    end
  end

  assign top   = entry0_q;
  assign depth = depth_q;

endmodule

// File: rtl/cpu_program_counter.sv
// Fetch-stage controller: PC register, next-PC selection and the registered
// nop_insert flag that squashes the word fetched behind a taken transfer.
module cpu_program_counter
  import cpu_program_counter_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_program_counter_if.slave  bus
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                nop_insert_q, nop_insert_d;
  logic                qualified;
  logic                push, pop;
  pc_sel_e             sel;
  logic [PC_WIDTH-1:0] stack_top;
  logic [1:0]          stack_depth;

  // A squashed NOP in the execute slot must never request a transfer.
  always_comb begin
    qualified = !bus.stall && !nop_insert_q;
    sel       = SEL_INC;
    if (qualified) begin
      if (bus.retlw_en)          sel = SEL_RET;
      else if (bus.call_en)      sel = SEL_CALL;
      else if (bus.goto_en)      sel = SEL_GOTO;
      else if (bus.pcl_write_en) sel = SEL_PCL;
    end
    pop  = (sel == SEL_RET);
    push = (sel == SEL_CALL);
  end

  always_comb begin
    pc_d         = pc_q;
    nop_insert_d = nop_insert_q;
    if (!bus.stall) begin
      unique case (sel)
        SEL_RET:  pc_d = stack_top;
        SEL_CALL: pc_d = PC_WIDTH'(bus.target[7:0]);
        SEL_GOTO: pc_d = PC_WIDTH'(bus.target);
        SEL_PCL:  pc_d = PC_WIDTH'(bus.pcl_data);
        default:  pc_d = pc_q + PC_WIDTH'(1);
      endcase
      nop_insert_d = qualified && ((sel != SEL_INC) || bus.skip_en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      nop_insert_q <= 1'b1;
    end else begin
      pc_q         <= pc_d;
      nop_insert_q <= nop_insert_d;
    end
  end

  // The PC register is the address of the next fetched word, i.e. the return address.
  cpu_call_stack #(
    .WIDTH (PC_WIDTH)
  ) u_call_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q),
    .top       (stack_top),
    .depth     (stack_depth)
  );

  assign bus.rom_addr    = pc_q;
  assign bus.nop_insert  = nop_insert_q;
  assign bus.stack_depth = stack_depth;

endmodule

// File: tb/tb_cpu_program_counter.sv
// Directed and randomized bench for cpu_program_counter, checked against a
// cycle-level behavioural model of the fetch stage kept in this file.
module tb_cpu_program_counter;

  localparam int PCW  = 9;
  localparam int PMOD = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_program_counter_if #(.PC_WIDTH(PCW)) bus ();

  cpu_program_counter #(
    .PC_WIDTH     (PCW),
    .RESET_VECTOR (9'h1FF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: PC value, squash flag, and return stack as a 2-entry queue (front = top).
  int m_pc;
  int m_nop;
  int m_depth;
  int m_stk[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit q;
    if (reset) begin
      m_pc    = 'h1FF;
      m_nop   = 1;
      m_depth = 0;
      m_stk   = '{0, 0};
    end else if (!bus.stall) begin
      q = (m_nop == 0);
      if (q && bus.retlw_en) begin
        m_pc = m_stk.pop_front();
        m_stk.push_back(m_stk[0]);
        m_depth = (m_depth > 0) ? m_depth - 1 : 0;
      end else if (q && bus.call_en) begin
        m_stk.push_front(m_pc);
        void'(m_stk.pop_back());
        m_depth = (m_depth < 2) ? m_depth + 1 : 2;
        m_pc = int'(bus.target) % 256;
      end else if (q && bus.goto_en) begin
        m_pc = int'(bus.target);
      end else if (q && bus.pcl_write_en) begin
        m_pc = int'(bus.pcl_data);
      end else begin
        m_pc = (m_pc + 1) % PMOD;
      end
      m_nop = (q && (bus.retlw_en || bus.call_en || bus.goto_en ||
                     bus.pcl_write_en || bus.skip_en)) ? 1 : 0;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, ".rom_addr"}, 16'(bus.rom_addr),    16'(m_pc));
    check({tag, ".nop"},      16'(bus.nop_insert),  16'(m_nop));
    check({tag, ".depth"},    16'(bus.stack_depth), 16'(m_depth));
  endtask

  task automatic clear_ctrl();
    bus.stall        = 1'b0;
    bus.goto_en      = 1'b0;
    bus.call_en      = 1'b0;
    bus.retlw_en     = 1'b0;
    bus.pcl_write_en = 1'b0;
    bus.skip_en      = 1'b0;
    bus.target       = '0;
    bus.pcl_data     = '0;
  endtask

  // Lands the PC on addr with nop_insert low, via a goto to addr-1.
  task automatic land_at(input logic [8:0] addr);
    bus.goto_en = 1'b1;
    bus.target  = addr - 9'd1;
    tick("land_goto");
    clear_ctrl();
    tick("land_settle");
    check("land.rom_addr", 16'(bus.rom_addr), 16'(addr));
  endtask

  initial begin
    reset = 1'b1;
    clear_ctrl();

    // 1. reset and release
    for (int i = 0; i < 3; i++) begin
      tick("reset");
      check("reset.rom_const", 16'(bus.rom_addr), 16'h1FF);
      check("reset.nop_const", 16'(bus.nop_insert), 16'h1);
      check("reset.depth_const", 16'(bus.stack_depth), 16'h0);
    end
    reset = 1'b0;
    check("rel1.rom_addr", 16'(bus.rom_addr), 16'h1FF);
    check("rel1.nop", 16'(bus.nop_insert), 16'h1);
    tick("rel2");
    check("rel2.rom_addr", 16'(bus.rom_addr), 16'h000);
    check("rel2.nop", 16'(bus.nop_insert), 16'h0);
    tick("rel3");
    check("rel3.rom_addr", 16'(bus.rom_addr), 16'h001);

    // 2. goto and PCL write
    for (int i = 0; i < 16; i++) tick("count");
    check("count.rom_addr", 16'(bus.rom_addr), 16'h011);
    bus.goto_en = 1'b1;
    bus.target  = 9'h0A5;
    tick("goto");
    check("goto.rom_addr", 16'(bus.rom_addr), 16'h0A5);
    check("goto.nop", 16'(bus.nop_insert), 16'h1);
    clear_ctrl();
    tick("goto_after");
    check("goto_after.rom_addr", 16'(bus.rom_addr), 16'h0A6);
    check("goto_after.nop", 16'(bus.nop_insert), 16'h0);
    bus.pcl_write_en = 1'b1;
    bus.pcl_data     = 8'h7F;
    tick("pcl");
    check("pcl.rom_addr", 16'(bus.rom_addr), 16'h07F);
    check("pcl.nop", 16'(bus.nop_insert), 16'h1);
    clear_ctrl();
    tick("pcl_after");
    check("pcl_after.nop", 16'(bus.nop_insert), 16'h0);

    // 3. call / return
    land_at(9'h021);
    bus.call_en = 1'b1;
    bus.target  = 9'h1C3;
    tick("call");
    check("call.rom_addr", 16'(bus.rom_addr), 16'h0C3);
    check("call.depth", 16'(bus.stack_depth), 16'h1);
    check("call.nop", 16'(bus.nop_insert), 16'h1);
    clear_ctrl();
    tick("call_after");
    bus.retlw_en = 1'b1;
    tick("ret");
    check("ret.rom_addr", 16'(bus.rom_addr), 16'h021);
    check("ret.depth", 16'(bus.stack_depth), 16'h0);
    check("ret.nop", 16'(bus.nop_insert), 16'h1);
    clear_ctrl();
    tick("ret_after");

    // 4. three nested calls, four returns
    land_at(9'h010);
    begin
      logic [8:0]  tgt[3]     = '{9'h04F, 9'h08F, 9'h0F0};
      logic [15:0] dcall[3]   = '{16'h1, 16'h2, 16'h2};
      logic [15:0] rtgt[4]    = '{16'h090, 16'h050, 16'h050, 16'h050};
      logic [15:0] dret[4]    = '{16'h1, 16'h0, 16'h0, 16'h0};
      for (int i = 0; i < 3; i++) begin
        bus.call_en = 1'b1;
        bus.target  = tgt[i];
        tick("ncall");
        check("ncall.depth", 16'(bus.stack_depth), dcall[i]);
        clear_ctrl();
        tick("ncall_after");
      end
      for (int i = 0; i < 4; i++) begin
        bus.retlw_en = 1'b1;
        tick("nret");
        check("nret.rom_addr", 16'(bus.rom_addr), rtgt[i]);
        check("nret.depth", 16'(bus.stack_depth), dret[i]);
        clear_ctrl();
        tick("nret_after");
      end
    end

    // 5. skip, and a goto ignored while squashing
    land_at(9'h030);
    bus.skip_en = 1'b1;
    tick("skip");
    check("skip.rom_addr", 16'(bus.rom_addr), 16'h031);
    check("skip.nop", 16'(bus.nop_insert), 16'h1);
    clear_ctrl();
    bus.goto_en = 1'b1;
    bus.target  = 9'h100;
    tick("squashed_goto");
    check("squashed_goto.rom_addr", 16'(bus.rom_addr), 16'h032);
    check("squashed_goto.nop", 16'(bus.nop_insert), 16'h0);

    // 6. stall, then reset after a call
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick("stall");
      check("stall.rom_addr", 16'(bus.rom_addr), 16'h032);
      check("stall.nop", 16'(bus.nop_insert), 16'h0);
      check("stall.depth", 16'(bus.stack_depth), 16'h0);
    end
    clear_ctrl();
    tick("unstall");
    check("unstall.rom_addr", 16'(bus.rom_addr), 16'h033);
    bus.call_en = 1'b1;
    bus.target  = 9'h040;
    tick("precall");
    check("precall.depth", 16'(bus.stack_depth), 16'h1);
    clear_ctrl();
    reset = 1'b1;
    tick("reset_mid");
    check("reset_mid.rom_addr", 16'(bus.rom_addr), 16'h1FF);
    check("reset_mid.depth", 16'(bus.stack_depth), 16'h0);
    reset = 1'b0;
    tick("reset_mid_rel");

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bus.stall        = ($urandom_range(7) == 0);
      bus.goto_en      = ($urandom_range(9) == 0);
      bus.call_en      = ($urandom_range(7) == 0);
      bus.retlw_en     = ($urandom_range(7) == 0);
      bus.pcl_write_en = ($urandom_range(11) == 0);
      bus.skip_en      = ($urandom_range(7) == 0);
      bus.target       = 9'($urandom);
      bus.pcl_data     = 8'($urandom);
      reset            = ($urandom_range(99) == 0);
      tick("rand");
    end
    reset = 1'b0;
    clear_ctrl();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_program_counter.md
Name: cpu_program_counter

Overview:
Fetch-stage controller for the PIC10-compatible core. It holds the program counter and the 2-level hardware call stack, and drives the program ROM address. It also generates the registered nop_insert flag that the downstream NOP-insert mux uses to squash the fetched word after any taken control transfer. Control requests come from the execute stage for the instruction currently leaving the mux.

Parameters:
PC_WIDTH, 9, program counter / ROM address width.
RESET_VECTOR, {PC_WIDTH{1'b1}} (0x1FF), PC value loaded on reset.

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold all state; control inputs ignored while high
goto_en  input  1  executing instruction is GOTO
call_en  input  1  executing instruction is CALL
retlw_en  input  1  executing instruction is RETLW
pcl_write_en  input  1  executing instruction writes PCL
skip_en  input  1  executing skip instruction whose condition is true
target  input  9  instruction k field (GOTO uses [8:0], CALL uses [7:0])
pcl_data  input  8  value written to PCL
rom_addr  output  PC_WIDTH  program ROM address, equal to the PC register
nop_insert  output  1  registered; the mux replaces the ROM word with NOP this cycle
stack_depth  output  2  valid stack entries, 0..2 (debug/verification)

Behaviour:
- ROM is synchronous: the word for rom_addr issued in cycle t appears on the program bus in t+1, when it is executed. A redirect decided in t+1 loads the PC for t+2. The word arriving in t+2 is I(a+1) and must be squashed, so nop_insert=1 in t+2.
- Reset (synchronous, takes priority over everything): PC=RESET_VECTOR, stack entries cleared to 0, stack_depth=0, nop_insert=1. Reset asserted mid-transfer discards the transfer.
- First cycle after reset release: rom_addr=RESET_VECTOR, nop_insert=1 because the ROM output is stale. The next cycle: PC=0x000 and nop_insert=0.
- Control inputs are qualified by (!stall && !nop_insert). A squashed NOP cannot request a transfer.
- With stall high: PC, stack, stack_depth and nop_insert all hold.
- Next-PC priority when qualified, highest first:
  - retlw: PC=stack0.
  - call: PC={0,target[7:0]}.
  - goto: PC=target[PC_WIDTH-1:0].
  - pcl_write: PC={0,pcl_data}.
  - otherwise PC+1.
  - Simultaneous requests are a decoder error but resolve by this order.
- PC increment wraps modulo 2^PC_WIDTH (0x1FF -> 0x000).
- nop_insert_next = qualified(retlw|call|goto|pcl_write|skip_en). skip_en never alters the PC.
- Call push: stack1<=stack0, stack0<=PC (address after the CALL). stack_depth saturates at 2; a third push silently loses the oldest entry.
- Return pop: PC<=stack0, stack0<=stack1, stack1 unchanged. stack_depth decrements and saturates at 0. Underflow returns stack0 without error.
- rom_addr is combinational from the PC register only; no combinational path from the control inputs.

Decomposition:
- definition.vh (shared include):
  - NOP encoding 12'h000
  - default PC_WIDTH
  - RESET_VECTOR
  - opcode constants used by the decoder that drives the *_en inputs
- One sub-module: cpu_call_stack.
  - Contains the two entries and the depth counter.
  - Ports: clk, reset, push, pop, push_data, top, depth.
- The PC register, next-PC mux and nop_insert register stay in cpu_program_counter.

Test Plan:
1. Reset held 3 cycles, then released -> during reset rom_addr=0x1FF, nop_insert=1, stack_depth=0. After release: cycle 1 rom_addr=0x1FF, nop_insert=1. Cycle 2: rom_addr=0x000, nop_insert=0. Cycle 3: 0x001.
2. PC=0x011; goto_en with target=0x0A5 in the execute cycle -> next rom_addr=0x0A5, nop_insert=1 for exactly one cycle, then 0x0A6 with nop_insert=0. pcl_write_en with pcl_data=0x7F -> rom_addr=0x07F, nop=1 one cycle.
3. call_en at PC=0x021 with target=0x1C3 -> rom_addr=0x0C3 (bit 8 cleared), stack_depth=1, nop=1. Later retlw_en -> rom_addr=0x021, stack_depth=0, nop=1.
4. Three nested calls with return addresses 0x010, 0x050, 0x090, then four retlw -> returns go to 0x090, 0x050, 0x050, 0x050. stack_depth goes 1,2,2 then 1,0,0,0.
5. skip_en at PC=0x030 -> rom_addr continues 0x031, nop_insert=1 for one cycle. A goto_en asserted while nop_insert=1 is ignored.
6. stall high for 2 cycles with goto_en=1 and target=0x100 -> rom_addr, nop_insert and stack_depth unchanged. After stall drops with controls low, PC resumes +1. Reset asserted in the cycle after a call -> PC=0x1FF, stack_depth=0.
